etch_a_sketch_vram_painter: RTL

//  Upstream producer for the ILI9341 display controller. Turns touch events (touch_t from the FT6206 path)

---
 rtl/etch_a_sketch_vram_painter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/etch_a_sketch_vram_painter.sv
// Etch-a-sketch VRAM painter.
// Turns accepted touch events into BRUSH_SIZE x BRUSH_SIZE squares of pen colour on
// the write port of the frame-buffer VRAM. It sweeps the whole VRAM to BG_COLOR
// after reset and whenever a clear is requested.
// The touch bus is packed as {valid, x[8:0], y[8:0]}.
module etch_a_sketch_vram_painter #(
   parameter int          DISPLAY_WIDTH  = 240,
   parameter int          DISPLAY_HEIGHT = 320,
   parameter int          VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
   parameter int          BRUSH_SIZE     = 4,
   parameter logic [15:0] BG_COLOR       = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic [18:0]               touch,
   input  logic [15:0]               pen_color,
   input  logic                      clear_req,
   output logic                      busy,
   output logic                      vram_wr_ena,
   output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
   output logic [15:0]               vram_wr_data
);

   localparam int AW = $clog2(VRAM_L);
   localparam int BW = $clog2(BRUSH_SIZE + 1);
   localparam logic [9:0]    W10       = 10'(DISPLAY_WIDTH);
   localparam logic [9:0]    H10       = 10'(DISPLAY_HEIGHT);
   localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);
   localparam logic [BW-1:0] LAST_OFS  = BW'(BRUSH_SIZE - 1);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_PAINT
   } state_t;

   state_t        state;
   logic [AW-1:0] sweep_cnt;
   logic [8:0]    last_x;
   logic [8:0]    last_y;
   logic [9:0]    x0;
   logic [9:0]    y0;
   logic [15:0]   color;
   logic [BW-1:0] dx;
   logic [BW-1:0] dy;

   // Touch bus fields
   logic       touch_valid;
   logic [8:0] touch_x;
   logic [8:0] touch_y;
   assign touch_valid = touch[18];
   assign touch_x     = touch[17:9];
   assign touch_y     = touch[8:0];

   // A touch is worth painting only if it is on screen and differs from the last accepted point
   logic touch_ok;
   assign touch_ok = touch_valid
                     && ({1'b0, touch_x} < W10)
                     && ({1'b0, touch_y} < H10)
                     && !((touch_x == last_x) && (touch_y == last_y));

   // Current brush pixel; 10 bits leave headroom for x0 + BRUSH_SIZE - 1
   logic [9:0]    px;
   logic [9:0]    py;
   logic          pix_in;
   logic [AW-1:0] paint_addr;
   assign px     = x0 + 10'(dx);
   assign py     = y0 + 10'(dy);
   assign pix_in = (px < W10) && (py < H10);
   // Only the low AW bits of the row-major address are kept; the dropped MSB cannot
   // affect them, and in-bounds pixels always fit below VRAM_L.
   assign paint_addr = AW'(py) * AW'(DISPLAY_WIDTH) + AW'(px);

   // Main controller: clear sweep, idle arbitration and brush walk, all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_CLEAR;
         sweep_cnt    <= '0;
         last_x       <= '1;
         last_y       <= '1;
         x0           <= '0;
         y0           <= '0;
         color        <= '0;
         dx           <= '0;
         dy           <= '0;
         busy         <= 1'b1;
         vram_wr_ena  <= 1'b0;
         vram_wr_addr <= '0;
         vram_wr_data <= '0;
      end else if (ena) begin
         case (state)
            S_CLEAR: begin
               vram_wr_ena  <= 1'b1;
               vram_wr_addr <= sweep_cnt;
               vram_wr_data <= BG_COLOR;
               sweep_cnt    <= sweep_cnt + AW'(1);
               if (sweep_cnt == LAST_ADDR) begin
                  sweep_cnt <= '0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_IDLE: begin
               vram_wr_ena <= 1'b0;
               if (clear_req) begin
                  sweep_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= S_CLEAR;
               end else if (touch_ok) begin
                  x0     <= {1'b0, touch_x};
                  y0     <= {1'b0, touch_y};
                  color  <= pen_color;
                  last_x <= touch_x;
                  last_y <= touch_y;
                  dx     <= '0;
                  dy     <= '0;
                  busy   <= 1'b1;
                  state  <= S_PAINT;
               end else begin
                  busy <= 1'b0;
               end
            end
            S_PAINT: begin
               if (clear_req) begin
                  // Abort the stroke; the sweep starts writing on the following edge
                  vram_wr_ena <= 1'b0;
                  sweep_cnt   <= '0;
                  busy        <= 1'b1;
                  state       <= S_CLEAR;
               end else begin
                  // Off-screen brush pixels still consume a cycle but do not write
                  vram_wr_ena  <= pix_in;
                  vram_wr_addr <= paint_addr;
                  vram_wr_data <= color;
                  if (dx == LAST_OFS) begin
                     dx <= '0;
                     if (dy == LAST_OFS) begin
                        dy    <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end else begin
                        dy <= dy + BW'(1);
                     end
                  end else begin
                     dx <= dx + BW'(1);
                  end
               end
            end
            default: begin
               vram_wr_ena <= 1'b0;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule
